aspect_rect_animator: RTL and testbench
=======================================

Name: aspect_rect_animator

Overview:
- Parametrised successor to the fixed 16:9 rectangle-on generator in the video overlay path.
- Generates a configurable-aspect rectangle mask and border mask for each pixel coordinate.
- Scale ("granularity") is frame-synchronous and can jump, ramp toward a target, or bounce continuously.
- Registered output, 1-cycle latency. Sits between the pixel-coordinate counter and the overlay mixer.

Parameters:
- COORD_W, 11, pixel coordinate width
- GRAN_W, 7, granularity width
- GRAN_MAX, 120, maximum legal granularity
- GRAN_RESET, 1, granularity after reset
- ASPECT_W, 16, pixels of width per granularity unit
- ASPECT_H, 9, pixels of height per granularity unit
- X_START, 100, rectangle left edge
- Y_START, 50, rectangle top edge
- H_ACTIVE, 1920, active width; rectangle right edge clipped here
- V_ACTIVE, 1080, active height; bottom edge clipped here
- BORDER, 2, border thickness in pixels
- STEP_FRAMES, 4, frames per ramp/bounce step (must be >=1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of each frame
- pixel_valid  in  1  pixel_x/pixel_y valid this cycle
- pixel_x  in  COORD_W  pixel column
- pixel_y  in  COORD_W  pixel row
- gran_target  in  GRAN_W  requested granularity
- mode  in  2  00 STATIC, 01 RAMP, 10 BOUNCE, 11 FREEZE
- out_valid  out  1  pixel_valid delayed 1 cycle
- rect_on  out  1  pixel inside rectangle
- rect_edge  out  1  pixel inside rectangle and within BORDER px of any edge
- gran_cur  out  GRAN_W  granularity in force this frame
- busy  out  1  gran_cur != clamped target (RAMP), or BOUNCE active

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, rect_on=0, rect_edge=0, gran_cur=GRAN_RESET, busy=0; state=HOLD, frame counter=0. Reset mid-frame aborts any ramp; the next frame uses GRAN_RESET.
- Target clamp: 0 -> 1; >GRAN_MAX -> GRAN_MAX. Sampled only on frame_start.
- mode is sampled only on frame_start. A mode change clears the frame counter.
- gran_cur, rect_w and rect_h update only on the frame_start edge and are registered together, so there is no hazard.
  - rect_w = min(ASPECT_W*gran, H_ACTIVE-X_START).
  - rect_h = min(ASPECT_H*gran, V_ACTIVE-Y_START).
  - Products are computed at COORD_W+GRAN_W bits before clipping; no overflow.
- States (advance on frame_start only):
  - HOLD: STATIC -> gran_cur = target immediately. RAMP with gran != target -> RAMP_UP or RAMP_DOWN. BOUNCE -> BOUNCE_UP. FREEZE -> stay.
  - RAMP_UP / RAMP_DOWN: counter counts frame_starts. At STEP_FRAMES-1, gran_cur ±1 and counter clears. On reaching target -> HOLD. If the target crosses to the other side, change direction on the next frame_start. A new target takes effect without restart.
  - BOUNCE_UP / BOUNCE_DOWN: step ±1 every STEP_FRAMES frames. Reverse at GRAN_MAX or 1; the endpoint is held for one step period.
  - Any state with mode=FREEZE -> HOLD, gran_cur unchanged. STATIC from any state -> HOLD with gran_cur = target.
- Pixel stage (1 cycle): out_valid <= pixel_valid.
  - rect_on <= pixel_valid & X_START<=x<X_START+rect_w & Y_START<=y<Y_START+rect_h.
  - rect_edge <= rect_on_comb & (x<X_START+BORDER | x>=X_START+rect_w-BORDER | y<Y_START+BORDER | y>=Y_START+rect_h-BORDER).
  - When pixel_valid=0, rect_on and rect_edge are 0.
- frame_start coincident with pixel_valid: that pixel uses the pre-update dimensions.
- If rect_w or rect_h < 2*BORDER, every inside pixel is an edge pixel.

Decomposition:
- Package aspect_pkg:
  - mode_e enum (STATIC/RAMP/BOUNCE/FREEZE)
  - state_e enum (HOLD/RAMP_UP/RAMP_DOWN/BOUNCE_UP/BOUNCE_DOWN)
  - clamp_gran function
  - default aspect constants 16/9 and 4/3
- Sub-module gran_sequencer: FSM, frame counter, gran_cur and busy.
- Top level: dimension multiply/clip and pixel compare pipeline.

Test Plan:
- Reset then STATIC, target=10, frame_start. Pixel (100,50) -> rect_on=1, rect_edge=1 one cycle later. (259,139) -> rect_on=1. (260,139) -> rect_on=0. (101+2,52) -> rect_edge=0.
- RAMP, gran 10 -> target 13, STEP_FRAMES=4. gran_cur=11/12/13 after frame_starts 4/8/12; busy drops with gran_cur=13; state HOLD.
- BOUNCE from 119. Steps 119 -> 120, holds 120 one step period, then 119. At gran 120, rect_w clips to 1820, so pixel_x=1919 gives rect_on=1.
- Target 0 -> gran_cur=1. Target 127 -> gran_cur=120. mode change mid-frame -> no effect until frame_start.
- frame_start and pixel_valid together while STATIC changes 10 -> 20. Pixel (300,60) -> rect_on=0 (old dims). Next pixel (300,60) -> rect_on=1.
- rst_n=0 during RAMP at gran 50. Next cycle: gran_cur=1, out_valid=0, busy=0.

Source files
------------

// File: rtl/aspect_pkg.sv
// aspect_pkg: shared types, aspect presets and target clamp for the rectangle animator.
package aspect_pkg;

    typedef enum logic [1:0] {STATIC = 2'b00, RAMP = 2'b01, BOUNCE = 2'b10, FREEZE = 2'b11} mode_e;
    typedef enum logic [2:0] {HOLD, RAMP_UP, RAMP_DOWN, BOUNCE_UP, BOUNCE_DOWN} state_e;

    localparam int ASPECT_16_9_W = 16;
    localparam int ASPECT_16_9_H = 9;
    localparam int ASPECT_4_3_W  = 4;
    localparam int ASPECT_4_3_H  = 3;

    function automatic int clamp_gran(int t, int gmax);
        return (t < 1) ? 1 : ((t > gmax) ? gmax : t);
    endfunction

endpackage

// File: rtl/gran_sequencer.sv
// gran_sequencer: frame-synchronous granularity FSM (jump, ramp, bounce, freeze).
module gran_sequencer
    import aspect_pkg::*;
#(
    parameter int GRAN_W      = 7,
    parameter int GRAN_MAX    = 120,
    parameter int GRAN_RESET  = 1,
    parameter int STEP_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [GRAN_W-1:0] gran_target,
    input  logic [1:0]        mode,
    output logic [GRAN_W-1:0] gran_cur,
    output logic [GRAN_W-1:0] gran_nxt,
    output logic              busy
);

    localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, m;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
    logic [GRAN_W-1:0] gran_q, gran_d, tgt;
    logic              hit, up;

    always_comb begin
        m        = mode_e'(mode);
        tgt      = GRAN_W'(clamp_gran(int'(gran_target), GRAN_MAX));
        cnt_base = (m != mode_q) ? '0 : cnt_q;
        hit      = cnt_base == CNT_W'(STEP_FRAMES - 1);
        up       = (state_q == BOUNCE_DOWN) ? (gran_q <= GRAN_W'(1)) : (gran_q < GRAN_W'(GRAN_MAX));
        state_d  = state_q;
        mode_d   = mode_q;
        gran_d   = gran_q;
        cnt_d    = cnt_q;
        if (frame_start) begin
            mode_d = m;
            cnt_d  = hit ? '0 : cnt_base + 1'b1;
            case (m)
                STATIC: begin
                    state_d = HOLD;
                    gran_d  = tgt;
                    cnt_d   = '0;
                end
                FREEZE: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
                RAMP: begin
                    // direction re-evaluated every frame so a crossing target reverses the ramp
                    if (hit && gran_q != tgt)
                        gran_d = (tgt > gran_q) ? gran_q + 1'b1 : gran_q - 1'b1;
                    state_d = (gran_d == tgt) ? HOLD : ((tgt > gran_q) ? RAMP_UP : RAMP_DOWN);
                    if (gran_d == tgt)
                        cnt_d = '0;
                end
                default: begin
                    if (hit)
                        gran_d = up ? gran_q + 1'b1 : gran_q - 1'b1;
                    state_d = (hit ? up : (state_q != BOUNCE_DOWN)) ? BOUNCE_UP : BOUNCE_DOWN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HOLD;
            mode_q  <= STATIC;
            cnt_q   <= '0;
            gran_q  <= GRAN_W'(GRAN_RESET);
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            gran_q  <= gran_d;
        end
    end

    assign gran_cur = gran_q;
    assign gran_nxt = gran_d;
    assign busy     = state_q != HOLD;

endmodule

// File: rtl/aspect_rect_animator.sv
// aspect_rect_animator: configurable-aspect rectangle and border mask with animated scale.
module aspect_rect_animator
    import aspect_pkg::*;
#(
    parameter int COORD_W     = 11,
    parameter int GRAN_W      = 7,
    parameter int GRAN_MAX    = 120,
    parameter int GRAN_RESET  = 1,
    parameter int ASPECT_W    = ASPECT_16_9_W,
    parameter int ASPECT_H    = ASPECT_16_9_H,
    parameter int X_START     = 100,
    parameter int Y_START     = 50,
    parameter int H_ACTIVE    = 1920,
    parameter int V_ACTIVE    = 1080,
    parameter int BORDER      = 2,
    parameter int STEP_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [GRAN_W-1:0]  gran_target,
    input  logic [1:0]         mode,
    output logic               out_valid,
    output logic               rect_on,
    output logic               rect_edge,
    output logic [GRAN_W-1:0]  gran_cur,
    output logic               busy
);

    localparam int PW = COORD_W + GRAN_W;
    localparam int CW = COORD_W + 2;

    logic [GRAN_W-1:0]  gran_nxt, g;
    logic [PW-1:0]      pw, ph;
    logic [COORD_W-1:0] rect_w_q, rect_w_d, rect_h_q, rect_h_d;
    logic [CW-1:0]      x, y, x0, y0, x1, y1;
    logic               in_c, edge_c;

    gran_sequencer #(
        .GRAN_W(GRAN_W), .GRAN_MAX(GRAN_MAX), .GRAN_RESET(GRAN_RESET), .STEP_FRAMES(STEP_FRAMES)
    ) u_seq (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .gran_target(gran_target),
        .mode(mode), .gran_cur(gran_cur), .gran_nxt(gran_nxt), .busy(busy)
    );

    always_comb begin
        // dimensions track the sequencer's next value so they load on the same edge as gran_cur
        g        = rst_n ? gran_nxt : GRAN_W'(GRAN_RESET);
        pw       = PW'(ASPECT_W) * PW'(g);
        ph       = PW'(ASPECT_H) * PW'(g);
        rect_w_d = (pw > PW'(H_ACTIVE - X_START)) ? COORD_W'(H_ACTIVE - X_START) : COORD_W'(pw);
        rect_h_d = (ph > PW'(V_ACTIVE - Y_START)) ? COORD_W'(V_ACTIVE - Y_START) : COORD_W'(ph);
        x        = CW'(pixel_x);
        y        = CW'(pixel_y);
        x0       = CW'(X_START);
        y0       = CW'(Y_START);
        x1       = x0 + CW'(rect_w_q);
        y1       = y0 + CW'(rect_h_q);
        in_c     = pixel_valid && x >= x0 && x < x1 && y >= y0 && y < y1;
        edge_c   = in_c && (x < x0 + CW'(BORDER) || x + CW'(BORDER) >= x1 ||
                            y < y0 + CW'(BORDER) || y + CW'(BORDER) >= y1);
    end

    always_ff @(posedge clk) begin
        rect_w_q <= rect_w_d;
        rect_h_q <= rect_h_d;
        if (!rst_n) begin
            out_valid <= 1'b0;
            rect_on   <= 1'b0;
            rect_edge <= 1'b0;
        end else begin
            out_valid <= pixel_valid;
            rect_on   <= in_c;
            rect_edge <= edge_c;
        end
    end

endmodule

// File: tb/tb_aspect_rect_animator.sv
// tb_aspect_rect_animator: directed scoreboard bench for the rectangle animator.
module tb_aspect_rect_animator;

    logic        clk = 1'b0;
    logic        rst_n, frame_start, pixel_valid;
    logic [10:0] pixel_x, pixel_y;
    logic [6:0]  gran_target;
    logic [1:0]  mode;
    logic        out_valid, rect_on, rect_edge, busy;
    logic [6:0]  gran_cur;

    int errors = 0;
    int checks = 0;
    logic [1:0] sb[$];

    aspect_rect_animator dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .gran_target(gran_target), .mode(mode),
        .out_valid(out_valid), .rect_on(rect_on), .rect_edge(rect_edge),
        .gran_cur(gran_cur), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
            else chk("pixel_on_edge", {30'd0, rect_on, rect_edge}, {30'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int px, input int py, input logic eo, input logic ee);
        pixel_valid = 1'b1;
        pixel_x     = 11'(px);
        pixel_y     = 11'(py);
        sb.push_back({eo, ee});
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
        pixel_x = '0; pixel_y = '0; gran_target = 7'd0; mode = 2'b00;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_rect_on", rect_on, 0);
        chk("rst_gran", gran_cur, 1);
        chk("rst_busy", busy, 0);

        gran_target = 7'd10; mode = 2'b00; fs();
        chk("static_gran10", gran_cur, 10);
        chk("static_busy", busy, 0);
        pix(100, 50, 1, 1);
        pix(259, 139, 1, 1);
        pix(260, 139, 0, 0);
        pix(103, 52, 1, 0);
        pix(99, 50, 0, 0);
        pix(150, 140, 0, 0);
        tick();
        chk("idle_rect_on", rect_on, 0);
        chk("idle_out_valid", out_valid, 0);

        gran_target = 7'd0; fs();
        chk("clamp_low", gran_cur, 1);
        pix(115, 58, 1, 1);
        pix(116, 58, 0, 0);
        gran_target = 7'd127; fs();
        chk("clamp_high", gran_cur, 120);
        pix(1919, 100, 1, 1);
        pix(1000, 1079, 1, 1);
        pix(1000, 500, 1, 0);

        mode = 2'b11; gran_target = 7'd5;
        repeat (3) tick();
        chk("midframe_no_effect", gran_cur, 120);
        fs();
        chk("freeze_hold", gran_cur, 120);
        chk("freeze_busy", busy, 0);

        mode = 2'b00; gran_target = 7'd10; fs();
        gran_target = 7'd20;
        frame_start = 1'b1;
        pix(300, 60, 0, 0);
        frame_start = 1'b0;
        chk("coincident_gran", gran_cur, 20);
        pix(300, 60, 1, 0);

        gran_target = 7'd10; fs();
        mode = 2'b01; gran_target = 7'd13;
        for (int k = 1; k <= 12; k++) begin
            fs();
            chk("ramp_gran", gran_cur, 10 + k / 4);
            chk("ramp_busy", busy, (k < 12) ? 1 : 0);
        end

        mode = 2'b00; gran_target = 7'd119; fs();
        mode = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            fs();
            chk("bounce_gran", gran_cur, (k < 4) ? 119 : (k < 8) ? 120 : (k < 12) ? 119 : 118);
            chk("bounce_busy", busy, 1);
        end

        mode = 2'b00; gran_target = 7'd48; fs();
        mode = 2'b01; gran_target = 7'd60;
        repeat (8) fs();
        chk("ramp_at_50", gran_cur, 50);
        chk("ramp_busy_50", busy, 1);
        rst_n = 1'b0; pixel_valid = 1'b1; pixel_x = 11'd120; pixel_y = 11'd60;
        tick();
        rst_n = 1'b1; pixel_valid = 1'b0;
        chk("mid_rst_gran", gran_cur, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rect_on", rect_on, 0);
        pix(115, 58, 1, 1);
        pix(116, 58, 0, 0);
        tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
